// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - instruction field layout and opcode constants for decode_rf_pipe
package decode_pkg;

   localparam int OPC_LSB  = 25;
   localparam int OPC_W    = 7;
   localparam int DST_LSB  = 20;
   localparam int SRC1_LSB = 15;
   localparam int SRC2_LSB = 10;
   localparam int REG_W    = 5;
   localparam int OFF_LSB  = 0;
   localparam int OFF_W    = 10;

   localparam logic [OPC_W-1:0] OP_LOAD    = 7'h03;
   localparam logic [OPC_W-1:0] OP_ALU_IMM = 7'h13;
   localparam logic [OPC_W-1:0] OP_STORE   = 7'h23;
   localparam logic [OPC_W-1:0] OP_ALU     = 7'h33;

   localparam logic [OPC_W-1:0] LOAD_OP_DEFAULT = OP_LOAD;

endpackage

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - architectural register array, two combinational reads, one write
module regfile_2r1w #(
   parameter int XLEN       = 32,
   parameter int NREG       = 32,
   parameter int ZERO_REG   = 0,
   parameter int RESET_INIT = 1,
   localparam int AW        = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [AW-1:0]   raddr1,
   input  logic [AW-1:0]   raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2
);

   logic [XLEN-1:0] regs [NREG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= (RESET_INIT != 0) ? XLEN'(i + 10) : '0;
      end else if (we && !(ZERO_REG != 0 && waddr == '0)) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata1 = (ZERO_REG != 0 && raddr1 == '0) ? '0 : regs[raddr1];
   assign rdata2 = (ZERO_REG != 0 && raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/decode_rf_pipe.sv
// rtl/decode_rf_pipe.sv - decode stage with register read, writeback bypass and load-use scoreboard
module decode_rf_pipe #(
   parameter int         XLEN       = 32,
   parameter int         NREG       = 32,
   parameter int         ZERO_REG   = 0,
   parameter int         RESET_INIT = 1,
   parameter logic [6:0] LOAD_OP    = decode_pkg::LOAD_OP_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instruction,
   input  logic            flush,
   input  logic            wb_en,
   input  logic [4:0]      wb_dst,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [6:0]      opcode,
   output logic [4:0]      dst,
   output logic [4:0]      src1_reg,
   output logic [4:0]      src2_reg,
   output logic [9:0]      offsetlo,
   output logic [XLEN-1:0] offset_sext,
   output logic [XLEN-1:0] src1,
   output logic [XLEN-1:0] src2,
   output logic            hazard_stall
);
   import decode_pkg::*;

   localparam int AW = $clog2(NREG);

   logic [AW-1:0]   s1_idx, s2_idx, wb_idx, held_dst_idx;
   logic [XLEN-1:0] rf_rd1, rf_rd2, op1, op2;
   logic [NREG-1:0] pending;
   logic            wb_hit1, wb_hit2, hazard, slot_free, accept, load_retire;

   assign s1_idx       = instruction[SRC1_LSB +: AW];
   assign s2_idx       = instruction[SRC2_LSB +: AW];
   assign wb_idx       = wb_dst[AW-1:0];
   assign held_dst_idx = dst[AW-1:0];

   regfile_2r1w #(
      .XLEN(XLEN), .NREG(NREG), .ZERO_REG(ZERO_REG), .RESET_INIT(RESET_INIT)
   ) u_rf (
      .clk(clk), .rst_n(rst_n),
      .we(wb_en), .waddr(wb_idx), .wdata(wb_data),
      .raddr1(s1_idx), .raddr2(s2_idx),
      .rdata1(rf_rd1), .rdata2(rf_rd2)
   );

   assign wb_hit1 = wb_en && (wb_idx == s1_idx);
   assign wb_hit2 = wb_en && (wb_idx == s2_idx);

   // Register 0 stays zero even when a writeback to it is being bypassed.
   always_comb begin
      op1 = wb_hit1 ? wb_data : rf_rd1;
      op2 = wb_hit2 ? wb_data : rf_rd2;
      if (ZERO_REG != 0 && s1_idx == '0) op1 = '0;
      if (ZERO_REG != 0 && s2_idx == '0) op2 = '0;
   end

   // A held load is not yet in the scoreboard, so it is matched directly.
   assign hazard = (pending[s1_idx] && !wb_hit1) || (pending[s2_idx] && !wb_hit2) ||
                   (out_valid && opcode == LOAD_OP &&
                    (held_dst_idx == s1_idx || held_dst_idx == s2_idx));

   assign slot_free    = !out_valid || out_ready;
   assign in_ready     = slot_free && !hazard && !flush;
   assign hazard_stall = slot_free && hazard && !flush;
   assign accept       = in_valid && in_ready;
   assign load_retire  = out_valid && out_ready && !flush && opcode == LOAD_OP;

   // Set is applied last so it wins over a same-edge writeback clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else begin
         if (wb_en)       pending[wb_idx]       <= 1'b0;
         if (load_retire) pending[held_dst_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         opcode      <= '0;
         dst         <= '0;
         src1_reg    <= '0;
         src2_reg    <= '0;
         offsetlo    <= '0;
         offset_sext <= '0;
         src1        <= '0;
         src2        <= '0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         opcode      <= instruction[OPC_LSB +: OPC_W];
         dst         <= instruction[DST_LSB +: REG_W];
         src1_reg    <= instruction[SRC1_LSB +: REG_W];
         src2_reg    <= instruction[SRC2_LSB +: REG_W];
         offsetlo    <= instruction[OFF_LSB +: OFF_W];
         offset_sext <= {{(XLEN-OFF_W){instruction[OFF_LSB+OFF_W-1]}}, instruction[OFF_LSB +: OFF_W]};
         src1        <= op1;
         src2        <= op2;
      end else if (flush || out_ready) begin
         out_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_rf_pipe.sv
// tb/tb_decode_rf_pipe.sv - directed self-checking bench for decode_rf_pipe
module tb_decode_rf_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, flush, wb_en, out_valid, out_ready, hazard_stall;
   logic [31:0] instruction, wb_data, offset_sext, src1, src2;
   logic [4:0]  wb_dst, dst, src1_reg, src2_reg;
   logic [6:0]  opcode;
   logic [9:0]  offsetlo;

   logic        z_in_ready, z_out_valid, z_hazard_stall;
   logic [31:0] z_offset_sext, z_src1, z_src2;
   logic [4:0]  z_dst, z_src1_reg, z_src2_reg;
   logic [6:0]  z_opcode;
   logic [9:0]  z_offsetlo;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   decode_rf_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .flush(flush), .wb_en(wb_en), .wb_dst(wb_dst),
      .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
      .opcode(opcode), .dst(dst), .src1_reg(src1_reg), .src2_reg(src2_reg),
      .offsetlo(offsetlo), .offset_sext(offset_sext), .src1(src1), .src2(src2),
      .hazard_stall(hazard_stall)
   );

   decode_rf_pipe #(.ZERO_REG(1)) dut_z (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(z_in_ready),
      .instruction(instruction), .flush(flush), .wb_en(wb_en), .wb_dst(wb_dst),
      .wb_data(wb_data), .out_valid(z_out_valid), .out_ready(out_ready),
      .opcode(z_opcode), .dst(z_dst), .src1_reg(z_src1_reg), .src2_reg(z_src2_reg),
      .offsetlo(z_offsetlo), .offset_sext(z_offset_sext), .src1(z_src1), .src2(z_src2),
      .hazard_stall(z_hazard_stall)
   );

   function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] d,
                                      input logic [4:0] s1, input logic [4:0] s2,
                                      input logic [9:0] off);
      return {op, d, s1, s2, off};
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 0; instruction = '0; flush = 0;
      wb_en = 0; wb_dst = '0; wb_data = '0; out_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else passed++; total++;
      if (src1 !== 32'd0) $display("FAIL rst_src1 got %h exp 0", src1); else passed++; total++;
      if (opcode !== 7'd0) $display("FAIL rst_opcode got %h exp 0", opcode); else passed++; total++;
      if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", in_ready); else passed++; total++;
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      out_ready = 1; in_valid = 1; instruction = mk(7'h33, 5'd2, 5'd3, 5'd4, 10'h3FF);
      #1;
      if (in_ready !== 1'b1) $display("FAIL basic_in_ready got %b exp 1", in_ready); else passed++; total++;
      step; in_valid = 0;
      if (out_valid !== 1'b1) $display("FAIL basic_out_valid got %b exp 1", out_valid); else passed++; total++;
      if (src1 !== 32'd13) $display("FAIL basic_src1 got %h exp %h", src1, 32'd13); else passed++; total++;
      if (src2 !== 32'd14) $display("FAIL basic_src2 got %h exp %h", src2, 32'd14); else passed++; total++;
      if (dst !== 5'd2 || opcode !== 7'h33) $display("FAIL basic_fields got %h/%h exp 02/33", dst, opcode); else passed++; total++;
      if (offsetlo !== 10'h3FF) $display("FAIL basic_offlo got %h exp 3ff", offsetlo); else passed++; total++;
      if (offset_sext !== 32'hFFFFFFFF) $display("FAIL basic_sext got %h exp ffffffff", offset_sext); else passed++; total++;
      step;
      if (out_valid !== 1'b0) $display("FAIL basic_drain got %b exp 0", out_valid); else passed++; total++;
   endtask

   task automatic test_bypass;
      in_valid = 1; instruction = mk(7'h33, 5'd1, 5'd3, 5'd9, 10'h005);
      wb_en = 1; wb_dst = 5'd3; wb_data = 32'h55;
      step; in_valid = 0; wb_en = 0;
      if (src1 !== 32'h55) $display("FAIL byp_src1 got %h exp 55", src1); else passed++; total++;
      if (src2 !== 32'd19) $display("FAIL byp_src2 got %h exp %h", src2, 32'd19); else passed++; total++;
      if (offset_sext !== 32'd5) $display("FAIL byp_sext got %h exp 5", offset_sext); else passed++; total++;
      step; in_valid = 1; instruction = mk(7'h33, 5'd1, 5'd3, 5'd3, 10'h0);
      step; in_valid = 0;
      if (src1 !== 32'h55 || src2 !== 32'h55) $display("FAIL byp_written got %h/%h exp 55/55", src1, src2); else passed++; total++;
      step;
   endtask

   task automatic test_stall;
      out_ready = 0; in_valid = 1; instruction = mk(7'h13, 5'd8, 5'd1, 5'd2, 10'h200);
      step; instruction = mk(7'h33, 5'd9, 5'd5, 5'd6, 10'h0);
      for (int k = 0; k < 3; k++) begin
         #1;
         if (in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d] got %b exp 0", k, in_ready); else passed++; total++;
         if (hazard_stall !== 1'b0) $display("FAIL stall_hz[%0d] got %b exp 0", k, hazard_stall); else passed++; total++;
         step;
         if (out_valid !== 1'b1 || dst !== 5'd8) $display("FAIL stall_hold[%0d] got %b/%h exp 1/08", k, out_valid, dst); else passed++; total++;
         if (src1 !== 32'd11 || src2 !== 32'd12) $display("FAIL stall_src[%0d] got %h/%h exp b/c", k, src1, src2); else passed++; total++;
         if (offset_sext !== 32'hFFFFFE00) $display("FAIL stall_sext[%0d] got %h exp fffffe00", k, offset_sext); else passed++; total++;
      end
      out_ready = 1;
      #1;
      if (in_ready !== 1'b1) $display("FAIL stall_release got %b exp 1", in_ready); else passed++; total++;
      step; in_valid = 0;
      if (dst !== 5'd9 || src1 !== 32'd15 || src2 !== 32'd16)
         $display("FAIL stall_next got %h/%h/%h exp 09/f/10", dst, src1, src2); else passed++; total++;
      step;
      if (out_valid !== 1'b0) $display("FAIL stall_drain got %b exp 0", out_valid); else passed++; total++;
   endtask

   task automatic test_load_use;
      out_ready = 1; in_valid = 1; instruction = mk(7'h03, 5'd7, 5'd1, 5'd2, 10'h0);
      step; instruction = mk(7'h33, 5'd10, 5'd1, 5'd7, 10'h0);
      #1;
      if (hazard_stall !== 1'b1 || in_ready !== 1'b0) $display("FAIL lu_held got %b/%b exp 1/0", hazard_stall, in_ready); else passed++; total++;
      step;
      if (out_valid !== 1'b0) $display("FAIL lu_retired got %b exp 0", out_valid); else passed++; total++;
      if (hazard_stall !== 1'b1 || in_ready !== 1'b0) $display("FAIL lu_pending got %b/%b exp 1/0", hazard_stall, in_ready); else passed++; total++;
      step;
      if (in_ready !== 1'b0) $display("FAIL lu_wait got %b exp 0", in_ready); else passed++; total++;
      wb_en = 1; wb_dst = 5'd7; wb_data = 32'hABCD;
      #1;
      if (hazard_stall !== 1'b0 || in_ready !== 1'b1) $display("FAIL lu_wb got %b/%b exp 0/1", hazard_stall, in_ready); else passed++; total++;
      step; wb_en = 0; in_valid = 0;
      if (out_valid !== 1'b1 || src2 !== 32'hABCD || src1 !== 32'd11)
         $display("FAIL lu_accept got %b/%h/%h exp 1/abcd/b", out_valid, src2, src1); else passed++; total++;
      step;
      if (in_ready !== 1'b1) $display("FAIL lu_cleared got %b exp 1", in_ready); else passed++; total++;
   endtask

   task automatic test_flush;
      out_ready = 0; in_valid = 1; instruction = mk(7'h03, 5'd5, 5'd1, 5'd2, 10'h0);
      step; instruction = mk(7'h33, 5'd11, 5'd5, 5'd0, 10'h0);
      flush = 1; out_ready = 1;
      #1;
      if (in_ready !== 1'b0 || hazard_stall !== 1'b0) $display("FAIL fl_cycle got %b/%b exp 0/0", in_ready, hazard_stall); else passed++; total++;
      step; flush = 0;
      if (out_valid !== 1'b0) $display("FAIL fl_out_valid got %b exp 0", out_valid); else passed++; total++;
      #1;
      if (in_ready !== 1'b1 || hazard_stall !== 1'b0) $display("FAIL fl_no_pending got %b/%b exp 1/0", in_ready, hazard_stall); else passed++; total++;
      step; in_valid = 0;
      if (out_valid !== 1'b1 || dst !== 5'd11 || src1 !== 32'd15 || src2 !== 32'd10)
         $display("FAIL fl_accept got %b/%h/%h/%h exp 1/0b/f/a", out_valid, dst, src1, src2); else passed++; total++;
      step;
   endtask

   task automatic test_reset_mid_stall;
      out_ready = 0; in_valid = 1; instruction = mk(7'h33, 5'd2, 5'd3, 5'd4, 10'h0);
      step; in_valid = 0;
      if (out_valid !== 1'b1 || src1 !== 32'h55) $display("FAIL rms_held got %b/%h exp 1/55", out_valid, src1); else passed++; total++;
      rst_n = 0;
      #1;
      if (out_valid !== 1'b0 || src1 !== 32'd0 || opcode !== 7'd0)
         $display("FAIL rms_async got %b/%h/%h exp 0/0/0", out_valid, src1, opcode); else passed++; total++;
      step; rst_n = 1;
      in_valid = 1; instruction = mk(7'h33, 5'd4, 5'd3, 5'd0, 10'h0); out_ready = 1;
      #1;
      if (in_ready !== 1'b1) $display("FAIL rms_ready got %b exp 1", in_ready); else passed++; total++;
      step; in_valid = 0;
      if (out_valid !== 1'b1 || src1 !== 32'd13) $display("FAIL rms_first got %b/%h exp 1/d", out_valid, src1); else passed++; total++;
      step;
   endtask

   task automatic test_zero_reg;
      in_valid = 1; instruction = mk(7'h33, 5'd1, 5'd0, 5'd1, 10'h0);
      wb_en = 1; wb_dst = 5'd0; wb_data = 32'hFF;
      #1;
      if (z_in_ready !== 1'b1) $display("FAIL zr_ready got %b exp 1", z_in_ready); else passed++; total++;
      step; wb_en = 0;
      if (z_src1 !== 32'd0 || z_src2 !== 32'd11) $display("FAIL zr_bypass got %h/%h exp 0/b", z_src1, z_src2); else passed++; total++;
      if (src1 !== 32'hFF) $display("FAIL zr_plain_bypass got %h exp ff", src1); else passed++; total++;
      instruction = mk(7'h33, 5'd1, 5'd0, 5'd0, 10'h0);
      step; in_valid = 0;
      if (z_src1 !== 32'd0 || z_src2 !== 32'd0) $display("FAIL zr_read got %h/%h exp 0/0", z_src1, z_src2); else passed++; total++;
      if (src1 !== 32'hFF || src2 !== 32'hFF) $display("FAIL zr_plain_read got %h/%h exp ff/ff", src1, src2); else passed++; total++;
      step;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_bypass;
      test_stall;
      test_load_use;
      test_flush;
      test_reset_mid_stall;
      test_zero_reg;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/decode_rf_pipe.md
DECODE_RF_PIPE -- requirements
Module: decode_rf_pipe

Interface
REQ-001 Parameter XLEN, default 32, register and operand data width (legal: 16..64).
REQ-002 Parameter NREG, default 32, architectural register count (legal: 8, 16, 32); register index = low log2(NREG) bits of the 5-bit fields.
REQ-003 Parameter ZERO_REG, default 0; when 1, register 0 reads as zero and ignores writes.
REQ-004 Parameter RESET_INIT, default 1; when 1, register i resets to i+10, else to 0.
REQ-005 Parameter LOAD_OP, default 7'h03, opcode whose result arrives late via writeback.
REQ-006 Port clk, input, 1, single clock; all state on rising edge.
REQ-007 Port rst_n, input, 1; reset is asynchronous and active-low.
REQ-008 Ports in_valid (in, 1), in_ready (out, 1), instruction (in, 32): upstream handshake.
REQ-009 Port flush, input, 1; discards the held output instruction.
REQ-010 Ports wb_en (in, 1), wb_dst (in, 5), wb_data (in, XLEN): writeback.
REQ-011 Ports out_valid (out, 1), out_ready (in, 1): downstream handshake.
REQ-012 Ports opcode (out, 7), dst (out, 5), src1_reg (out, 5), src2_reg (out, 5), offsetlo (out, 10), offset_sext (out, XLEN), src1 (out, XLEN), src2 (out, XLEN).
REQ-013 Port hazard_stall, output, 1; high when in_ready is low only because of a load-use hazard.

Function
REQ-014 Field map: opcode=[31:25], dst=[24:20], src1_reg=[19:15], src2_reg=[14:10], offsetlo=[9:0]; offset_sext = offsetlo sign-extended to XLEN.
REQ-015 Accept occurs when in_valid && in_ready; outputs update on the next edge, latency 1 cycle.
REQ-016 in_ready = (!out_valid || out_ready) && !hazard && !flush.
REQ-017 Outputs and out_valid hold stable while out_valid && !out_ready.
REQ-018 out_valid clears on the edge after out_ready handshake unless a new accept occurs that edge.
REQ-019 Register file: 2 read ports, 1 write port; write occurs on the edge when wb_en is high.
REQ-020 Bypass: if wb_en && wb_dst matches a source index in the accept cycle, that operand takes wb_data.
REQ-021 ZERO_REG=1: reads of index 0 return 0, including when bypass would otherwise apply.
REQ-022 Scoreboard: one pending bit per register, set on downstream handshake of an instruction with opcode==LOAD_OP, cleared by wb_en for that index.
REQ-023 Set and clear of the same bit on the same edge: set wins.
REQ-024 Hazard = either source index has a pending bit set and no same-cycle wb clears it, or out_valid && held opcode==LOAD_OP && held dst equals either source index.
REQ-025 Flush: out_valid clears next edge; no accept that cycle; scoreboard unaffected.
REQ-026 Flush and out_ready in the same cycle: instruction counts as flushed, no scoreboard set.

Reset
REQ-027 On rst_n low: out_valid=0, all data outputs 0, scoreboard all 0, registers per RESET_INIT.
REQ-028 Reset mid-stall discards the held instruction; first accept is possible in the first cycle after rst_n rises.

Structure
REQ-029 Package decode_pkg holds field bit positions, field widths, LOAD_OP default, opcode constants.
REQ-030 Sub-module regfile_2r1w (parameters XLEN, NREG, ZERO_REG, RESET_INIT) holds register array and write port; bypass and scoreboard stay in decode_rf_pipe.

Verification
REQ-031 After reset, instruction with src1=3, src2=4 and out_ready=1 -> next cycle src1=13, src2=14, out_valid=1.
REQ-032 Same-cycle wb_en, wb_dst=3, wb_data=0x55 while accepting src1=3 -> src1=0x55.
REQ-033 Load with dst=7 handshaken, next instruction src2=7 -> hazard_stall=1, in_ready=0 until wb_dst=7; accepted with src2=wb_data in that cycle.
REQ-034 out_ready=0 for 3 cycles -> all outputs stable; in_ready=0 throughout.
REQ-035 flush while a held load with dst=5 is present -> out_valid=0 next cycle, pending[5]=0, src1=5 instruction not stalled.
REQ-036 ZERO_REG=1, wb to register 0 with 0xFF, then read src1=0 -> src1=0.
